// File: rtl/key_matrix_scan_pkg.sv
// Shared encodings for the key matrix scanner: FSM states, special key codes,
// frame classification and auto-repeat timing.
package key_scan_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DEB  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam logic [4:0] KEY_CLR = 5'd16;
   localparam logic [4:0] KEY_BS  = 5'd17;

   localparam int unsigned REP_FIRST = 32;
   localparam int unsigned REP_NEXT  = 8;
   localparam int unsigned REP_W     = 6;

   typedef enum logic [1:0] {
      FR_NONE   = 2'd0,
      FR_SINGLE = 2'd1,
      FR_MULTI  = 2'd2
   } frame_res_e;

   typedef struct packed {
      frame_res_e res;
      logic [4:0] code;
   } frame_t;

   // Effect of one accepted key on the hex entry word.
   function automatic logic [31:0] hexs_apply(input logic [31:0] h, input logic [4:0] code);
      logic [31:0] r;
      r = h;
      if (code < KEY_CLR) begin
         r = {h[27:0], code[3:0]};
      end else if (code == KEY_CLR) begin
         r = '0;
      end else if (code == KEY_BS) begin
         r = h >> 4;
      end
      return r;
   endfunction

endpackage

// File: rtl/key_matrix_scan_frame.sv
// Row scanner: drives one row low per dwell period, samples the columns at the
// end of each dwell and classifies every complete 4-row frame.
module key_frame_scan
   import key_scan_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] key_col_i,
   output logic [3:0] key_row_o,
   output logic       frame_done_c_o,
   output frame_t     frame_c_o
);

   localparam int unsigned   DW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

   logic [DW-1:0] dwell_q, dwell_d;
   logic [1:0]    row_sel_q, row_sel_d;
   logic [3:0]    key_row_q, key_row_d;
   logic [1:0]    acc_cnt_q, acc_cnt_d;
   logic [4:0]    acc_code_q, acc_code_d;

   logic          sample_c;
   logic          frame_end_c;
   logic [4:0]    pressed_c;
   logic [1:0]    row_cnt_c;
   logic [2:0]    row_col_c;
   logic [2:0]    sum_c;
   logic [1:0]    tot_cnt_c;
   logic [4:0]    tot_code_c;

   // Pressed-bit count (saturating at 2) and column of the current row sample.
   always_comb begin
      pressed_c = ~key_col_i;
      row_cnt_c = 2'd0;
      row_col_c = 3'd0;
      for (int i = 0; i < 5; i++) begin
         if (pressed_c[i]) begin
            if (row_cnt_c != 2'd2) row_cnt_c = row_cnt_c + 2'd1;
            row_col_c = 3'(i);
         end
      end
   end

   always_comb begin
      sample_c    = (dwell_q == DWELL_LAST);
      frame_end_c = sample_c && (row_sel_q == 2'd3);

      sum_c      = {1'b0, acc_cnt_q} + {1'b0, row_cnt_c};
      tot_cnt_c  = (sum_c >= 3'd2) ? 2'd2 : sum_c[1:0];
      tot_code_c = (acc_cnt_q == 2'd0) ? (5'(row_sel_q) * 5'd5 + 5'(row_col_c)) : acc_code_q;

      dwell_d    = sample_c ? '0 : dwell_q + DW'(1);
      row_sel_d  = sample_c ? row_sel_q + 2'd1 : row_sel_q;
      key_row_d  = ~(4'b0001 << row_sel_d);
      acc_cnt_d  = acc_cnt_q;
      acc_code_d = acc_code_q;
      if (frame_end_c) begin
         acc_cnt_d  = 2'd0;
         acc_code_d = 5'd0;
      end else if (sample_c) begin
         acc_cnt_d  = tot_cnt_c;
         acc_code_d = tot_code_c;
      end

      frame_done_c_o = frame_end_c;
      frame_c_o.code = tot_code_c;
      case (tot_cnt_c)
         2'd0:    frame_c_o.res = FR_NONE;
         2'd1:    frame_c_o.res = FR_SINGLE;
         default: frame_c_o.res = FR_MULTI;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dwell_q    <= '0;
         row_sel_q  <= 2'd0;
         key_row_q  <= 4'b1110;
         acc_cnt_q  <= 2'd0;
         acc_code_q <= 5'd0;
      end else begin
         dwell_q    <= dwell_d;
         row_sel_q  <= row_sel_d;
         key_row_q  <= key_row_d;
         acc_cnt_q  <= acc_cnt_d;
         acc_code_q <= acc_code_d;
      end
   end

   assign key_row_o = key_row_q;

endmodule

// File: rtl/key_matrix_scan.sv
// 4x5 key matrix scanner with frame debounce, key events and hex entry word.
// Optional KEY_AUTOREPEAT_EN adds auto-repeat while a single key stays held.
module key_matrix_scan
   import key_scan_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned DEB_CNT  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  KEY_COL,
   output logic [3:0]  KEY_ROW,
   output logic        key_valid,
   output logic [4:0]  key_code,
   output logic        key_held,
   output logic [31:0] hexs
);

   localparam int unsigned   CW       = $clog2(DEB_CNT + 1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CNT);

   logic        frame_done_c;
   frame_t      frame_c;

   logic [1:0]    state_q, state_d;
   logic [4:0]    cand_q, cand_d;
   logic [CW-1:0] deb_q, deb_d;
   logic [CW-1:0] rel_q, rel_d;
   logic          key_valid_q, key_valid_d;
   logic [4:0]    key_code_q, key_code_d;
   logic          key_held_q, key_held_d;
   logic [31:0]   hexs_q, hexs_d;
   logic          accept_c;
   logic          single_c;
`ifdef KEY_AUTOREPEAT_EN
   logic [REP_W-1:0] rep_q, rep_d, rep_nx_c;
   assign rep_nx_c = rep_q + REP_W'(1);
`endif

   key_frame_scan #(
      .SCAN_DIV (SCAN_DIV)
   ) u_frame (
      .clk            (clk),
      .rst            (rst),
      .key_col_i      (KEY_COL),
      .key_row_o      (KEY_ROW),
      .frame_done_c_o (frame_done_c),
      .frame_c_o      (frame_c)
   );

   // Debounce / hold FSM, stepped once per completed frame.
   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      deb_d       = deb_q;
      rel_d       = rel_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      hexs_d      = hexs_q;
      accept_c    = 1'b0;
      single_c    = (frame_c.res == FR_SINGLE);
`ifdef KEY_AUTOREPEAT_EN
      rep_d       = rep_q;
`endif

      if (frame_done_c) begin
         case (state_q)
            S_IDLE: begin
               if (single_c) begin
                  cand_d = frame_c.code;
                  if (DEB_CNT == 1) begin
                     accept_c = 1'b1;
                     state_d  = S_HOLD;
                     rel_d    = '0;
                  end else begin
                     deb_d   = CW'(1);
                     state_d = S_DEB;
                  end
               end
            end
            S_DEB: begin
               if (!single_c) begin
                  state_d = S_IDLE;
                  deb_d   = '0;
               end else if (frame_c.code != cand_q) begin
                  cand_d = frame_c.code;
                  deb_d  = CW'(1);
               end else if (deb_q + CW'(1) == DEB_LAST) begin
                  accept_c = 1'b1;
                  state_d  = S_HOLD;
                  deb_d    = '0;
                  rel_d    = '0;
               end else begin
                  deb_d = deb_q + CW'(1);
               end
            end
            S_HOLD: begin
               if (frame_c.res == FR_NONE) begin
                  if (rel_q + CW'(1) == DEB_LAST) begin
                     state_d = S_IDLE;
                     rel_d   = '0;
                  end else begin
                     rel_d = rel_q + CW'(1);
                  end
               end else begin
                  rel_d = '0;
               end
`ifdef KEY_AUTOREPEAT_EN
               // After the first repeat the counter rewinds so later ones come every REP_NEXT frames.
               if (single_c && (frame_c.code == cand_q)) begin
                  if (rep_nx_c == REP_W'(REP_FIRST)) begin
                     accept_c = 1'b1;
                     rep_d    = REP_W'(REP_FIRST - REP_NEXT);
                  end else begin
                     rep_d = rep_nx_c;
                  end
               end else begin
                  rep_d = '0;
               end
`endif
            end
            default: state_d = S_IDLE;
         endcase
`ifdef KEY_AUTOREPEAT_EN
         if (state_q != S_HOLD) rep_d = '0;
`endif
      end

      if (accept_c) begin
         key_valid_d = 1'b1;
         key_code_d  = cand_d;
         hexs_d      = hexs_apply(hexs_q, cand_d);
      end
      key_held_d = (state_d == S_HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cand_q      <= 5'd0;
         deb_q       <= '0;
         rel_q       <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= 5'd0;
         key_held_q  <= 1'b0;
         hexs_q      <= 32'd0;
`ifdef KEY_AUTOREPEAT_EN
         rep_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cand_q      <= cand_d;
         deb_q       <= deb_d;
         rel_q       <= rel_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         key_held_q  <= key_held_d;
         hexs_q      <= hexs_d;
`ifdef KEY_AUTOREPEAT_EN
         rep_q       <= rep_d;
`endif
      end
   end

   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign key_held  = key_held_q;
   assign hexs      = hexs_q;

endmodule
